// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty path: default duty width, ramp FSM
// states and the step normalisation used when a new target is accepted.
package pwm_pkg;

    localparam int DUTY_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    // A step of zero would stall the ramp forever, so it is promoted to one.
    function automatic logic [3:0] eff_step(input logic [3:0] s);
        return (s == 4'd0) ? 4'd1 : s;
    endfunction

endpackage

// File: rtl/pwm_duty_ramp_tick_gen.sv
// Free-running prescaler: pulses tick for one cycle every PRESCALE clocks.
// Shared with pwm_generator as its period counter.
module ramp_tick_gen #(
    parameter int unsigned PRESCALE = 256
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..PRESCALE-1 and wrap; never resynchronised to the data path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty slew-rate limiter feeding pwm_generator. Accepts a target duty over
// valid/ready and walks duty toward it by at most step_q per prescaler tick.
// Optional feature: define PWM_RAMP_ABORT_EN to add an abort input that
// freezes duty and returns to IDLE without a done pulse.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 256,
    parameter int          DUTY_W   = DUTY_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [3:0]        step,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done
`ifdef PWM_RAMP_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int DW1 = DUTY_W + 1;

    // Saturating step toward tgt. Returns {reached, next_duty}. The distance
    // is formed one bit wider than duty so it can never wrap, and the target
    // is loaded directly whenever the remaining distance fits in one step.
    function automatic logic [DUTY_W:0] ramp_next(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [3:0]        stp,
        input logic              up
    );
        logic signed [DUTY_W:0] diff;
        logic signed [DUTY_W:0] stp_s;
        logic [DUTY_W-1:0]      nxt;
        logic                   reached;
        stp_s = DW1'(stp);
        if (up) begin
            diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        end else begin
            diff = $signed({1'b0, cur}) - $signed({1'b0, tgt});
        end
        reached = (diff <= stp_s);
        if (reached) begin
            nxt = tgt;
        end else if (up) begin
            nxt = cur + DUTY_W'(stp);
        end else begin
            nxt = cur - DUTY_W'(stp);
        end
        return {reached, nxt};
    endfunction

    ramp_state_t       state, state_d;
    logic [DUTY_W-1:0] duty_d, tgt_q, tgt_d;
    logic [3:0]        step_q, step_d;
    logic              done_d;
    logic              tick;
    logic [DUTY_W:0]   nxt;

    ramp_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Duty, target/step latches and the registered done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty   <= '0;
            tgt_q  <= '0;
            step_q <= 4'd1;
            done   <= 1'b0;
        end else begin
            duty   <= duty_d;
            tgt_q  <= tgt_d;
            step_q <= step_d;
            done   <= done_d;
        end
    end

    // Next-state, next-data and handshake outputs. A tick in the acceptance
    // cycle is ignored because acceptance only happens in IDLE.
    always_comb begin
        state_d   = state;
        duty_d    = duty;
        tgt_d     = tgt_q;
        step_d    = step_q;
        done_d    = 1'b0;
        nxt       = '0;
        tgt_ready = (state == IDLE);
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d  = tgt_duty;
                    step_d = eff_step(step);
                    if (tgt_duty > duty) begin
                        state_d = RAMP_UP;
                    end else if (tgt_duty < duty) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RAMP_UP, RAMP_DOWN: begin
`ifdef PWM_RAMP_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                end else
`endif
                if (tick) begin
                    nxt    = ramp_next(duty, tgt_q, step_q, state == RAMP_UP);
                    duty_d = nxt[DUTY_W-1:0];
                    if (nxt[DUTY_W]) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with PRESCALE=4.
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tgt_duty;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] step;
    logic [7:0] duty;
    logic       busy;
    logic       done;
`ifdef PWM_RAMP_ABORT_EN
    logic       abort;
`endif

    int total     = 0;
    int fail_cnt  = 0;
    int done_seen = 0;
    logic [7:0] prev;
    logic [7:0] up_seq [4] = '{8'd3, 8'd6, 8'd9, 8'd10};

    always #5 clk = ~clk;

    pwm_duty_ramp #(
        .PRESCALE(4),
        .DUTY_W  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tgt_duty (tgt_duty),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .step     (step),
        .duty     (duty),
        .busy     (busy),
        .done     (done)
`ifdef PWM_RAMP_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for duty to move away from prv, counting done pulses seen.
    task automatic wait_change(input logic [7:0] prv);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (duty !== prv) break;
        end
    endtask

    task automatic accept(input logic [7:0] t, input logic [3:0] s);
        tgt_duty  = t;
        step      = s;
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        if (done === 1'b1) done_seen++;
    endtask

    initial begin
        reset     = 1'b1;
        tgt_duty  = '0;
        tgt_valid = 1'b0;
        step      = '0;
`ifdef PWM_RAMP_ABORT_EN
        abort     = 1'b0;
`endif
        // 1. reset state and quiet period
        @(negedge clk);
        chk("rst_duty", 32'(duty), 0);
        chk("rst_ready", 32'(tgt_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("idle_done_count", 32'(done_seen), 0);
        chk("idle_duty", 32'(duty), 0);

        // 2. up ramp 0 -> 10 step 3, with ignored valid pulse mid-ramp
        done_seen = 0;
        accept(8'd10, 4'd3);
        chk("up_busy", 32'(busy), 1);
        chk("up_ready", 32'(tgt_ready), 0);
        for (int k = 0; k < 4; k++) begin
            prev = duty;
            wait_change(prev);
            chk("up_seq", 32'(duty), 32'(up_seq[k]));
            if (k == 0) begin
                tgt_duty  = 8'd50;
                tgt_valid = 1'b1;
                @(negedge clk);
                tgt_valid = 1'b0;
                if (done === 1'b1) done_seen++;
            end
        end
        chk("up_done", 32'(done), 1);
        chk("up_busy_fall", 32'(busy), 0);
        chk("up_ready_rise", 32'(tgt_ready), 1);
        chk("up_done_count", 32'(done_seen), 1);
        @(negedge clk);
        chk("up_done_low", 32'(done), 0);
        chk("up_hold", 32'(duty), 10);

        // 3a. down ramp 10 -> 0 with step 0 (treated as 1)
        done_seen = 0;
        accept(8'd0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            prev = duty;
            wait_change(prev);
            chk("down_seq", 32'(duty), 32'(9 - k));
        end
        chk("down_done", 32'(done), 1);
        chk("down_done_count", 32'(done_seen), 1);
        repeat (8) @(negedge clk);
        chk("down_no_wrap", 32'(duty), 0);

        // 3b. up ramp 0 -> 255 step 15, 17 ticks
        done_seen = 0;
        accept(8'd255, 4'd15);
        for (int k = 0; k < 17; k++) begin
            prev = duty;
            wait_change(prev);
            chk("full_up_seq", 32'(duty), 32'(15 * (k + 1)));
        end
        chk("full_up_done", 32'(done), 1);
        chk("full_up_done_count", 32'(done_seen), 1);

        // 4. equal target accepted in the done cycle
        accept(8'd255, 4'd2);
        chk("eq_done", 32'(done), 1);
        chk("eq_busy", 32'(busy), 0);
        chk("eq_ready", 32'(tgt_ready), 1);
        @(negedge clk);
        chk("eq_done_low", 32'(done), 0);
        chk("eq_duty", 32'(duty), 255);

        // 5. ramp down to 0, then async reset mid-ramp at duty 6
        accept(8'd0, 4'd15);
        for (int k = 0; k < 17; k++) begin
            prev = duty;
            wait_change(prev);
            chk("full_down_seq", 32'(duty), 32'(240 - 15 * k));
        end
        accept(8'd20, 4'd3);
        prev = duty;
        wait_change(prev);
        chk("rr_seq", 32'(duty), 3);
        prev = duty;
        wait_change(prev);
        chk("rr_seq", 32'(duty), 6);
        reset = 1'b1;
        #1;
        chk("async_rst_duty", 32'(duty), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_ready", 32'(tgt_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("after_rst_no_resume", 32'(duty), 0);
        done_seen = 0;
        accept(8'd5, 4'd5);
        prev = duty;
        wait_change(prev);
        chk("after_rst_ramp", 32'(duty), 5);
        chk("after_rst_done", 32'(done), 1);

`ifdef PWM_RAMP_ABORT_EN
        // 6. abort a 0 -> 200 ramp (step 8) at duty 64
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        accept(8'd200, 4'd8);
        for (int k = 0; k < 8; k++) begin
            prev = duty;
            wait_change(prev);
            chk("abort_seq", 32'(duty), 32'(8 * (k + 1)));
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", 32'(tgt_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("abort_hold", 32'(duty), 64);
        chk("abort_no_done", 32'(done_seen), 0);
`endif

        $display("%0d/%0d checks passed", total - fail_cnt, total);
        $finish;
    end

endmodule
